// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative square-root engine.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Root width for a given radicand width (one root bit per radicand bit pair).
  function automatic int root_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// Single restoring digit-by-digit square-root iteration (combinational).
// Shifts two radicand bits into the partial remainder, trial-subtracts
// {Q,01} and keeps the difference only if it did not borrow.
module sqrt_step #(
  parameter int ROOT_W = 4
) (
  input  logic [ROOT_W+1:0] r,
  input  logic [ROOT_W-1:0] q,
  input  logic [1:0]        d,
  output logic [ROOT_W+1:0] r_next,
  output logic [ROOT_W-1:0] q_next
);

  logic [ROOT_W+3:0] shifted;
  logic [ROOT_W+4:0] diff;
  logic [ROOT_W:0]   q_wide;
  logic              borrow;

  // Trial subtraction; the partial remainder never exceeds 2*Q, so the
  // extra high bits stay zero and the top bit of diff is the borrow.
  always_comb begin
    shifted = {r, d};
    diff    = {1'b0, shifted} - {3'b000, q, 2'b01};
    borrow  = diff[ROOT_W+4];
    r_next  = (ROOT_W+2)'(borrow ? shifted : diff[ROOT_W+3:0]);
    q_wide  = {q, ~borrow};
    q_next  = q_wide[ROOT_W-1:0];
  end

endmodule

// File: rtl/square_root_iterative.sv
// Iterative integer square root: one root bit per clock, start/ready/done
// handshake, results held until the next completed operation.
// Optional remainder output enabled by defining SQRT_REMAINDER_EN.
module square_root_iterative
  import sqrt_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int ROOT_W = root_w(WIDTH),
  localparam int CNT_W  = $clog2(WIDTH / 2) + 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [WIDTH-1:0]  radicand,
  output logic              ready,
  output logic              done,
  output logic [ROOT_W-1:0] root
`ifdef SQRT_REMAINDER_EN
  ,
  output logic [ROOT_W:0]   remainder
`endif
);

  state_t            state;
  logic [WIDTH-1:0]  d;
  logic [ROOT_W+1:0] r;
  logic [ROOT_W-1:0] q;
  logic [CNT_W-1:0]  cnt;
  logic [ROOT_W+1:0] r_next;
  logic [ROOT_W-1:0] q_next;

  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .r      (r),
    .q      (q),
    .d      (d[WIDTH-1 -: 2]),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Control FSM, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      root  <= '0;
      d     <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
`ifdef SQRT_REMAINDER_EN
      remainder <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d     <= radicand;
            r     <= '0;
            q     <= '0;
            cnt   <= CNT_W'(ROOT_W);
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          d   <= d << 2;
          cnt <= cnt - 1'b1;
          // Last iteration: publish the step outputs directly.
          if (cnt == CNT_W'(1)) begin
            root  <= q_next;
`ifdef SQRT_REMAINDER_EN
            remainder <= r_next[ROOT_W:0];
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_root_iterative.sv
// Self-checking bench: an 8-bit and a 16-bit engine on a shared clock/clear,
// checked cycle by cycle against an arithmetic isqrt model and the
// handshake timing (done one cycle after ROOT_W calc edges).
module tb_square_root_iterative;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        s8 = 1'b0, s16 = 1'b0;
  logic [7:0]  rad8 = '0;
  logic [15:0] rad16 = '0;
  logic        rdy8, dn8, rdy16, dn16;
  logic [3:0]  rt8;
  logic [7:0]  rt16;
`ifdef SQRT_REMAINDER_EN
  logic [4:0]  rem8;
  logic [8:0]  rem16;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  square_root_iterative #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .start(s8), .radicand(rad8),
    .ready(rdy8), .done(dn8), .root(rt8)
`ifdef SQRT_REMAINDER_EN
    , .remainder(rem8)
`endif
  );

  square_root_iterative #(.WIDTH(16)) dut16 (
    .clock(clock), .clear(clear), .start(s16), .radicand(rad16),
    .ready(rdy16), .done(dn16), .root(rt16)
`ifdef SQRT_REMAINDER_EN
    , .remainder(rem16)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: largest r with r*r <= x.
  function automatic longint isqrt(input longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic get_rdy(input bit w);
    return w ? rdy16 : rdy8;
  endfunction
  function automatic logic get_done(input bit w);
    return w ? dn16 : dn8;
  endfunction
  function automatic longint get_root(input bit w);
    return w ? longint'(rt16) : longint'(rt8);
  endfunction
`ifdef SQRT_REMAINDER_EN
  function automatic longint get_rem(input bit w);
    return w ? longint'(rem16) : longint'(rem8);
  endfunction
`endif

  task automatic drive(input bit w, input logic s, input longint x);
    if (w) begin s16 = s; rad16 = x[15:0]; end
    else   begin s8  = s; rad8  = x[7:0];  end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One operation; mask bit j raises start (with a junk radicand) in the
  // cycle after edge k+j, which must be ignored.
  task automatic op(input bit w, input longint x, input int mask);
    int rw = w ? 8 : 4;
    int t = 0;
    longint prev_r, er, em;
`ifdef SQRT_REMAINDER_EN
    longint prev_m = get_rem(w);
`endif
    while (!get_rdy(w) && t < 40) begin tick(); t++; end
    chk("ready_wait", 64'(get_rdy(w)), 64'd1);
    prev_r = get_root(w);
    er = isqrt(x);
    em = x - er * er;
    drive(w, 1'b1, x);
    tick();
    drive(w, 1'b0, longint'($urandom));
    for (int j = 0; j <= rw + 1; j++) begin
      chk("ready", 64'(get_rdy(w)), 64'(j == rw + 1));
      chk("done", 64'(get_done(w)), 64'(j == rw));
      if (j < rw) begin
        chk("root_hold", 64'(get_root(w)), 64'(prev_r));
`ifdef SQRT_REMAINDER_EN
        chk("rem_hold", 64'(get_rem(w)), 64'(prev_m));
`endif
      end else begin
        chk("root", 64'(get_root(w)), 64'(er));
`ifdef SQRT_REMAINDER_EN
        chk("rem", 64'(get_rem(w)), 64'(em));
`endif
      end
      if (j <= rw) begin
        drive(w, mask[j], longint'($urandom));
        tick();
        drive(w, 1'b0, longint'($urandom));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    tick(); tick();
    clear = 1'b0;
    chk("rst_ready8", 64'(rdy8), 64'd1);
    chk("rst_done8", 64'(dn8), 64'd0);
    chk("rst_root8", 64'(rt8), 64'd0);
    chk("rst_ready16", 64'(rdy16), 64'd1);
    chk("rst_root16", 64'(rt16), 64'd0);
`ifdef SQRT_REMAINDER_EN
    chk("rst_rem8", 64'(rem8), 64'd0);
`endif

    // Directed 8-bit cases, including boundaries and ignored start pulses.
    op(1'b0, 144, 0);
    op(1'b0, 200, 0);
    op(1'b0, 0, 0);
    op(1'b0, 255, 0);
    op(1'b0, 99, 32'b10010);
    op(1'b0, 50, 0);

    // Clear in the third CALC cycle abandons the operation.
    drive(1'b0, 1'b1, 225);
    tick();
    drive(1'b0, 1'b0, 0);
    tick(); tick();
    clear = 1'b1;
    tick();
    chk("clr_ready", 64'(rdy8), 64'd1);
    chk("clr_done", 64'(dn8), 64'd0);
    chk("clr_root", 64'(rt8), 64'd0);
`ifdef SQRT_REMAINDER_EN
    chk("clr_rem", 64'(rem8), 64'd0);
`endif
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("clr_no_done", 64'(dn8), 64'd0);
    end
    op(1'b0, 225, 0);

    // Directed 16-bit cases.
    op(1'b1, 65535, 0);
    op(1'b1, 40000, 0);
    op(1'b1, 0, 0);

    // Randomized operations with random ignored start pulses.
    for (int i = 0; i < 25; i++)
      op(1'b0, longint'($urandom_range(0, 255)), int'($urandom_range(0, 63)));
    for (int i = 0; i < 15; i++)
      op(1'b1, longint'($urandom_range(0, 65535)), int'($urandom_range(0, 1023)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
